// File: rtl/vga_pkg.sv
// Shared constants and types for the 160x120 12-bit framebuffer.
package vga_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 12;

  // One plotted point as it arrives from a waveform generator.
  typedef struct packed {
    logic [7:0]         x;
    logic [7:0]         y;
    logic [COLOR_W-1:0] color;
  } point_t;

  // Writer modes; the top module keeps matching encodings as plain constants.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/vga_plot_writer_if.sv
// Point stream, clear request and framebuffer write port of the plot writer.
interface vga_plot_writer_if;

  logic                         clear_req;
  logic [vga_pkg::COLOR_W-1:0]  clear_color;
  logic                         in_valid;
  logic                         in_ready;
  logic [7:0]                   in_x;
  logic [7:0]                   in_y;
  logic [vga_pkg::COLOR_W-1:0]  in_color;
  logic [vga_pkg::ADDR_W-1:0]   fb_addr;
  logic [vga_pkg::COLOR_W-1:0]  fb_data;
  logic                         fb_we;
  logic                         busy;
  logic [15:0]                  drop_count;

  // The writer side.
  modport slave (
    input  clear_req, clear_color, in_valid, in_x, in_y, in_color,
    output in_ready, fb_addr, fb_data, fb_we, busy, drop_count
  );

  // The point producer / framebuffer side.
  modport master (
    output clear_req, clear_color, in_valid, in_x, in_y, in_color,
    input  in_ready, fb_addr, fb_data, fb_we, busy, drop_count
  );

endinterface

// File: rtl/vga_xy_to_addr.sv
// Combinational (x, y) to linear framebuffer address with a range flag.
module vga_xy_to_addr
  import vga_pkg::*;
(
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  // 16 bits hold 255*160+255, so nothing wraps before the range check.
  logic [15:0] sum;
  logic        x_ok;
  logic        y_ok;

  assign sum  = 16'(y) * 16'(H_RES) + 16'(x);
  assign x_ok = 16'(x) < 16'(H_RES);
  assign y_ok = 16'(y) < 16'(V_RES);

  // The depth guard is implied by x_ok/y_ok but keeps the full sum in play.
  assign in_range = x_ok && y_ok && (sum < 16'(FB_DEPTH));
  assign addr     = sum[ADDR_W-1:0];

endmodule

// File: rtl/vga_plot_writer.sv
// Writes plotted points into the framebuffer and performs full-screen clears.
module vga_plot_writer
  import vga_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  vga_plot_writer_if.slave  bus
);

  localparam logic [0:0] ST_CLEAR  = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [0:0] ST_RESET  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] CLEAR_END = ADDR_W'(FB_DEPTH);

  logic [0:0]         state;
  logic [ADDR_W-1:0]  clr_addr;
  logic [COLOR_W-1:0] fill;
  logic               pending;
  logic               in_ready_q;
  logic               fb_we_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic [COLOR_W-1:0] fb_data_q;
  logic               busy_q;
  logic [15:0]        drop_cnt;

  point_t             pt;
  logic [ADDR_W-1:0]  pt_addr;
  logic               pt_in_range;
  logic               transfer;
  logic               clear_accept;

  assign pt           = {bus.in_x, bus.in_y, bus.in_color};
  assign transfer     = bus.in_valid && in_ready_q && (state == ST_RUN);
  assign clear_accept = bus.clear_req && (state == ST_RUN) && !pending;

  vga_xy_to_addr u_xy (
    .x        (pt.x),
    .y        (pt.y),
    .addr     (pt_addr),
    .in_range (pt_in_range)
  );

  // Mode control plus the registered write port: clear sweep or point writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RESET;
      clr_addr   <= '0;
      fill       <= '0;
      pending    <= 1'b0;
      in_ready_q <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          pending <= 1'b0;
          if (clr_addr == CLEAR_END) begin
            state      <= ST_RUN;
            clr_addr   <= '0;
            fb_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= clr_addr;
            fb_data_q <= fill;
            busy_q    <= 1'b1;
            clr_addr  <= clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          fb_we_q <= transfer && pt_in_range;
          if (transfer && pt_in_range) begin
            fb_addr_q <= pt_addr;
            fb_data_q <= pt.color;
          end
          if (clear_accept) begin
            fill       <= bus.clear_color;
            pending    <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= ST_CLEAR;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating tally of accepted points that fall outside the screen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (transfer && !pt_in_range && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_cnt;

endmodule

// File: tb/tb_vga_plot_writer.sv
// Directed bench for vga_plot_writer: reset clear, point writes, drops, clears.
module tb_vga_plot_writer;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  vga_plot_writer_if bus ();

  vga_plot_writer #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] x,
                               input logic [7:0] y, input logic [11:0] color);
    bus.in_valid = valid;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_color = color;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {fb_we, fb_addr, fb_data, busy, in_ready} as seen on the bus.
  function automatic logic [63:0] outVec();
    return {34'd0, bus.fb_we, bus.fb_addr, bus.fb_data, bus.busy, bus.in_ready};
  endfunction

  function automatic logic [63:0] expVec(input logic we, input logic [14:0] addr,
                                         input logic [11:0] data, input logic bsy,
                                         input logic rdy);
    return {34'd0, we, addr, data, bsy, rdy};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.clear_req   = 1'b0;
    bus.clear_color = 12'h000;
    applyStimulus(1'b0, 8'd0, 8'd0, 12'h000);

    tick();
    tick();
    checkOutput("reset_outputs", outVec(), expVec(1'b0, 15'd0, 12'h000, 1'b0, 1'b0));
    checkOutput("reset_drop", 64'(bus.drop_count), 64'd0);

    // Automatic clear after reset: 19200 back-to-back writes of colour 0.
    resetn = 1'b1;
    for (int k = 0; k < 19200; k++) begin
      tick();
      checkOutput("boot_clear", outVec(), expVec(1'b1, 15'(k), 12'h000, 1'b1, 1'b0));
    end
    tick();
    checkOutput("boot_clear_done", outVec(), expVec(1'b0, 15'd19199, 12'h000, 1'b0, 1'b1));

    // Three consecutive in-range points, including both corners.
    applyStimulus(1'b1, 8'd0, 8'd0, 12'hFFF);
    tick();
    checkOutput("pt_0_0", outVec(), expVec(1'b1, 15'd0, 12'hFFF, 1'b0, 1'b1));
    applyStimulus(1'b1, 8'd159, 8'd119, 12'h0F0);
    tick();
    checkOutput("pt_159_119", outVec(), expVec(1'b1, 15'd19199, 12'h0F0, 1'b0, 1'b1));
    applyStimulus(1'b1, 8'd10, 8'd3, 12'h123);
    tick();
    checkOutput("pt_10_3", outVec(), expVec(1'b1, 15'd490, 12'h123, 1'b0, 1'b1));

    // Idle with garbage coordinates: no write, no drop, outputs hold.
    applyStimulus(1'b0, 8'd200, 8'd200, 12'hABC);
    tick();
    checkOutput("idle_hold", outVec(), expVec(1'b0, 15'd490, 12'h123, 1'b0, 1'b1));
    checkOutput("idle_no_drop", 64'(bus.drop_count), 64'd0);

    // Out-of-range points are accepted but dropped and counted.
    applyStimulus(1'b1, 8'd160, 8'd5, 12'hFFF);
    tick();
    checkOutput("drop_x160", outVec(), expVec(1'b0, 15'd490, 12'h123, 1'b0, 1'b1));
    checkOutput("drop_cnt_1", 64'(bus.drop_count), 64'd1);
    applyStimulus(1'b1, 8'd5, 8'd120, 12'hFFF);
    tick();
    checkOutput("drop_y120", outVec(), expVec(1'b0, 15'd490, 12'h123, 1'b0, 1'b1));
    checkOutput("drop_cnt_2", 64'(bus.drop_count), 64'd2);
    applyStimulus(1'b1, 8'd255, 8'd255, 12'hFFF);
    tick();
    checkOutput("drop_255_255", outVec(), expVec(1'b0, 15'd490, 12'h123, 1'b0, 1'b1));
    checkOutput("drop_cnt_3", 64'(bus.drop_count), 64'd3);
    applyStimulus(1'b0, 8'd0, 8'd0, 12'h000);

    // Saturation: preload the counter at its ceiling, then drop once more.
    force dut.drop_cnt = 16'hFFFF;
    tick();
    release dut.drop_cnt;
    tick();
    checkOutput("drop_preload", 64'(bus.drop_count), 64'hFFFF);
    applyStimulus(1'b1, 8'd200, 8'd0, 12'h555);
    tick();
    checkOutput("drop_saturate", 64'(bus.drop_count), 64'hFFFF);
    checkOutput("drop_sat_no_we", 64'(bus.fb_we), 64'd0);

    // Clear request together with a point: point lands first, then the sweep.
    applyStimulus(1'b1, 8'd20, 8'd20, 12'h00F);
    bus.clear_req   = 1'b1;
    bus.clear_color = 12'hF00;
    tick();
    checkOutput("clr_point_write", outVec(), expVec(1'b1, 15'd3220, 12'h00F, 1'b0, 1'b0));
    bus.clear_req   = 1'b0;
    bus.clear_color = 12'h0F0;
    applyStimulus(1'b1, 8'd1, 8'd1, 12'hABC);
    for (int k = 0; k < 19200; k++) begin
      tick();
      checkOutput("req_clear", outVec(), expVec(1'b1, 15'(k), 12'hF00, 1'b1, 1'b0));
      if (k == 99) begin
        bus.clear_req   = 1'b1;
        bus.clear_color = 12'h00F;
      end else if (k == 100) begin
        bus.clear_req   = 1'b0;
      end
    end
    tick();
    checkOutput("req_clear_done", outVec(), expVec(1'b0, 15'd19199, 12'hF00, 1'b0, 1'b1));
    tick();
    checkOutput("post_clear_pt", outVec(), expVec(1'b1, 15'd161, 12'hABC, 1'b0, 1'b1));
    applyStimulus(1'b0, 8'd0, 8'd0, 12'h000);

    // Start another clear and pull reset part-way through it.
    bus.clear_req   = 1'b1;
    bus.clear_color = 12'h0A5;
    tick();
    bus.clear_req   = 1'b0;
    checkOutput("clr2_accept", outVec(), expVec(1'b0, 15'd161, 12'hABC, 1'b0, 1'b0));
    for (int k = 0; k < 5000; k++) begin
      tick();
    end
    checkOutput("clr2_at_4999", outVec(), expVec(1'b1, 15'd4999, 12'h0A5, 1'b1, 1'b0));
    resetn = 1'b0;
    #1;
    checkOutput("async_reset", outVec(), expVec(1'b0, 15'd0, 12'h000, 1'b0, 1'b0));
    checkOutput("async_reset_drop", 64'(bus.drop_count), 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("restart_clear", outVec(), expVec(1'b1, 15'(k), 12'h000, 1'b1, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
